// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Module      : alu_defs (package)
// Description : ALU control codes, main-control ALU classes, R-type funct
//               values and the shared (alu_op, funct) decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_defs;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic alu_src;
    } ex_ctrl_t;

    // Unknown R-type funct maps to INVALID so the ALU produces zero.
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] code;
        code = ALU_INVALID;
        case (alu_op_e'(op))
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_OR:  code = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_SLT: code = ALU_SLT;
                    FUNCT_NOR: code = ALU_NOR;
                    default:   code = ALU_INVALID;
                endcase
            end
            default: code = ALU_INVALID;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of ID-side, forwarding-source and EX-side signals of
//               the ID/EX stage; master = pipeline control, slave = stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic          id_uses_rt;
    logic          id_reg_dst;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          id_branch;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;

    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] store_data;
    logic [RW-1:0] ex_write_reg;
    logic          ex_valid;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_branch;
    logic          load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rt, id_reg_dst, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_branch, id_alu_op, id_funct,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_ctrl, store_data, ex_write_reg, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rt, id_reg_dst, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_branch, id_alu_op, id_funct,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_ctrl, store_data, ex_write_reg, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use_hazard
    );
endinterface
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_control
// Description : Combinational (alu_op, funct) to 4-bit ALU control decode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control
    import alu_defs::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o
);

    assign alu_ctrl_o = alu_decode(alu_op_i, funct_i);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with ALU-control decode, EX/MEM and
//               MEM/WB operand forwarding and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import alu_defs::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    logic          ex_valid_q,     ex_valid_d;
    ex_ctrl_t      ctrl_q,         ctrl_d;
    logic [3:0]    alu_ctrl_q,     alu_ctrl_d;
    logic [DW-1:0] rs_data_q,      rs_data_d;
    logic [DW-1:0] rt_data_q,      rt_data_d;
    logic [DW-1:0] imm_q,          imm_d;
    logic [RW-1:0] rs_q,           rs_d;
    logic [RW-1:0] rt_q,           rt_d;
    logic [RW-1:0] write_reg_q,    write_reg_d;

    logic [3:0]    w_id_alu_ctrl;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    alu_control u_alu_control (
        .alu_op_i   (bus.id_alu_op),
        .funct_i    (bus.id_funct),
        .alu_ctrl_o (w_id_alu_ctrl)
    );

    always_comb begin
        ex_valid_d           = bus.id_valid;
        ctrl_d.reg_write     = bus.id_reg_write;
        ctrl_d.mem_read      = bus.id_mem_read;
        ctrl_d.mem_write     = bus.id_mem_write;
        ctrl_d.mem_to_reg    = bus.id_mem_to_reg;
        ctrl_d.branch        = bus.id_branch;
        ctrl_d.alu_src       = bus.id_alu_src;
        alu_ctrl_d           = w_id_alu_ctrl;
        rs_data_d            = bus.id_rs_data;
        rt_data_d            = bus.id_rt_data;
        imm_d                = bus.id_imm;
        rs_d                 = bus.id_rs;
        rt_d                 = bus.id_rt;
        write_reg_d          = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    end

    // Flush clears only validity/controls; data registers keep stale values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ctrl_q      <= '0;
            alu_ctrl_q  <= ALU_INVALID;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            write_reg_q <= '0;
        end else if (bus.flush) begin
            ex_valid_q  <= 1'b0;
            ctrl_q      <= '0;
        end else if (!bus.stall) begin
            ex_valid_q  <= ex_valid_d;
            ctrl_q      <= ctrl_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            write_reg_q <= write_reg_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it is checked first; r0 never forwards.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] r,
        input logic [DW-1:0] rf_data,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_res,
        input logic          mw_we,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_res
    );
        logic [DW-1:0] v;
        v = rf_data;
        if (r != '0) begin
            if (em_we && (em_rd == r))
                v = em_res;
            else if (mw_we && (mw_rd == r))
                v = mw_res;
        end
        return v;
    endfunction

    always_comb begin
        w_fwd_rs = fwd_sel(rs_q, rs_data_q,
                           bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                           bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
        w_fwd_rt = fwd_sel(rt_q, rt_data_q,
                           bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                           bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    end

    assign bus.alu_a         = w_fwd_rs;
    assign bus.alu_b         = ctrl_q.alu_src ? imm_q : w_fwd_rt;
    assign bus.store_data    = w_fwd_rt;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.ex_write_reg  = write_reg_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_valid_q & ctrl_q.reg_write;
    assign bus.ex_mem_read   = ex_valid_q & ctrl_q.mem_read;
    assign bus.ex_mem_write  = ex_valid_q & ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ex_valid_q & ctrl_q.mem_to_reg;
    assign bus.ex_branch     = ex_valid_q & ctrl_q.branch;

    assign bus.load_use_hazard = ex_valid_q & ctrl_q.mem_read & (write_reg_q != '0)
                               & ((write_reg_q == bus.id_rs)
                                  | (bus.id_uses_rt & (write_reg_q == bus.id_rt)))
                               & bus.id_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed, table-driven self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic clk;
    logic reset;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        reg_dst;
        logic        alu_src;
        logic [4:0]  ctl;      // reg_write, mem_read, mem_write, mem_to_reg, branch
        logic        vin;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_st;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_wr;
        logic        e_v;
        logic [4:0]  e_ctl;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_checks;
    int n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_alu_op       = v.op;
        bus.id_funct        = v.funct;
        bus.id_reg_dst      = v.reg_dst;
        bus.id_alu_src      = v.alu_src;
        bus.id_reg_write    = v.ctl[4];
        bus.id_mem_read     = v.ctl[3];
        bus.id_mem_write    = v.ctl[2];
        bus.id_mem_to_reg   = v.ctl[1];
        bus.id_branch       = v.ctl[0];
        bus.id_valid        = v.vin;
        bus.id_uses_rt      = 1'b1;
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.id_rd           = v.rd;
        bus.id_rs_data      = v.rs_data;
        bus.id_rt_data      = v.rt_data;
        bus.id_imm          = v.imm;
        bus.exmem_reg_write = v.xw;
        bus.exmem_rd        = v.xrd;
        bus.exmem_result    = v.xres;
        bus.memwb_reg_write = v.ww;
        bus.memwb_rd        = v.wrd;
        bus.memwb_result    = v.wres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d alu_a", i),        bus.alu_a,        v.e_a);
        chk($sformatf("v%0d alu_b", i),        bus.alu_b,        v.e_b);
        chk($sformatf("v%0d store_data", i),   bus.store_data,   v.e_st);
        chk($sformatf("v%0d alu_ctrl", i),     32'(bus.alu_ctrl), 32'(v.e_ctrl));
        chk($sformatf("v%0d ex_write_reg", i), 32'(bus.ex_write_reg), 32'(v.e_wr));
        chk($sformatf("v%0d ex_valid", i),     32'(bus.ex_valid), 32'(v.e_v));
        chk($sformatf("v%0d ex_ctl", i),
            32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_mem_to_reg, bus.ex_branch}), 32'(v.e_ctl));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //              op     funct  rd ai ctl       v  rs    rt    rd    rs_data       rt_data       imm           xw  xrd   xres          ww  wrd   wres          e_a           e_b           e_st          ctrl     wr     v  ctl
        vecs[0]  = '{2'b10, 6'h20, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd5,        32'd7,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd5,        32'd7,        32'd7,        4'b0010, 5'd4,  1'b1, 5'b10000};
        vecs[1]  = '{2'b10, 6'h22, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd3, 5'd5, 5'd6, 32'd10,       32'd20,       32'd0,        1'b1, 5'd3, 32'hAAAA,     1'b1, 5'd3, 32'h5555,     32'hAAAA,     32'd20,       32'd20,       4'b0110, 5'd6,  1'b1, 5'b10000};
        vecs[2]  = '{2'b10, 6'h22, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd3, 5'd5, 5'd6, 32'd10,       32'd20,       32'd0,        1'b0, 5'd3, 32'hAAAA,     1'b1, 5'd3, 32'h5555,     32'h5555,     32'd20,       32'd20,       4'b0110, 5'd6,  1'b1, 5'b10000};
        vecs[3]  = '{2'b10, 6'h24, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd1, 5'd0, 5'd4, 32'd9,        32'd0,        32'd0,        1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'd0,        32'd9,        32'd0,        32'd0,        4'b0000, 5'd4,  1'b1, 5'b10000};
        vecs[4]  = '{2'b10, 6'h25, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd1, 5'd7, 5'd3, 32'd2,        32'd3,        32'd0,        1'b1, 5'd8, 32'hBEEF,     1'b1, 5'd7, 32'h1234,     32'd2,        32'h1234,     32'h1234,     4'b0001, 5'd3,  1'b1, 5'b10000};
        vecs[5]  = '{2'b10, 6'h2A, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd4, 5'd5, 5'd9, 32'd1,        32'd2,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd1,        32'd2,        32'd2,        4'b0111, 5'd9,  1'b1, 5'b10000};
        vecs[6]  = '{2'b10, 6'h27, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd4, 5'd5, 5'd10,32'd3,        32'd4,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd3,        32'd4,        32'd4,        4'b1100, 5'd10, 1'b1, 5'b10000};
        vecs[7]  = '{2'b00, 6'h00, 1'b0, 1'b1, 5'b00100, 1'b1, 5'd2, 5'd3, 5'd0, 32'd100,      32'd7,        32'hFFFFFFFC, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd100,      32'hFFFFFFFC, 32'd7,        4'b0010, 5'd3,  1'b1, 5'b00100};
        vecs[8]  = '{2'b00, 6'h00, 1'b0, 1'b1, 5'b00100, 1'b1, 5'd2, 5'd3, 5'd0, 32'd100,      32'd7,        32'd16,       1'b1, 5'd3, 32'h77,       1'b0, 5'd0, 32'd0,        32'd100,      32'd16,       32'h77,       4'b0010, 5'd3,  1'b1, 5'b00100};
        vecs[9]  = '{2'b01, 6'h00, 1'b0, 1'b0, 5'b00001, 1'b1, 5'd1, 5'd2, 5'd0, 32'd8,        32'd8,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd8,        32'd8,        32'd8,        4'b0110, 5'd2,  1'b1, 5'b00001};
        vecs[10] = '{2'b11, 6'h00, 1'b0, 1'b1, 5'b10000, 1'b1, 5'd1, 5'd2, 5'd0, 32'hF0,       32'd0,        32'h0F,       1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'hF0,       32'h0F,       32'd0,        4'b0001, 5'd2,  1'b1, 5'b10000};
        vecs[11] = '{2'b10, 6'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1,        32'd2,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd1,        32'd2,        32'd2,        4'b1111, 5'd3,  1'b1, 5'b10000};
        vecs[12] = '{2'b10, 6'h20, 1'b1, 1'b0, 5'b11111, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1,        32'd2,        32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'd1,        32'd2,        32'd2,        4'b0010, 5'd3,  1'b0, 5'b00000};
        vecs[13] = '{2'b00, 6'h00, 1'b0, 1'b1, 5'b11010, 1'b1, 5'd1, 5'd8, 5'd0, 32'h40,       32'd0,        32'd4,        1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        32'h40,       32'd4,        32'd0,        4'b0010, 5'd8,  1'b1, 5'b11010};

        // Reset held for two cycles with all inputs quiet.
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive('0);
        step();
        step();
        chk("reset alu_ctrl",   32'(bus.alu_ctrl), 32'hF);
        chk("reset ex_valid",   32'(bus.ex_valid), 32'd0);
        chk("reset alu_a",      bus.alu_a, 32'd0);
        chk("reset alu_b",      bus.alu_b, 32'd0);
        chk("reset write_reg",  32'(bus.ex_write_reg), 32'd0);
        chk("reset ctl",        32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                     bus.ex_mem_to_reg, bus.ex_branch}), 32'd0);
        chk("reset hazard",     32'(bus.load_use_hazard), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            step();
            check_vec(i, vecs[i]);
        end

        // Load-use: vecs[13] (lw into r8) now sits in EX.
        bus.id_valid   = 1'b1;
        bus.id_rs      = 5'd8;
        bus.id_rt      = 5'd9;
        bus.id_uses_rt = 1'b1;
        #1 chk("hazard rs match", 32'(bus.load_use_hazard), 32'd1);
        bus.id_rs      = 5'd1;
        bus.id_rt      = 5'd8;
        bus.id_uses_rt = 1'b0;
        #1 chk("hazard rt unused", 32'(bus.load_use_hazard), 32'd0);
        bus.id_uses_rt = 1'b1;
        #1 chk("hazard rt used", 32'(bus.load_use_hazard), 32'd1);
        bus.id_valid   = 1'b0;
        #1 chk("hazard id invalid", 32'(bus.load_use_hazard), 32'd0);

        // Stall for three cycles while ID inputs change, then stall+flush.
        drive(vecs[0]);
        step();
        drive(vecs[5]);
        bus.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d alu_a", c),     bus.alu_a, 32'd5);
            chk($sformatf("stall%0d alu_b", c),     bus.alu_b, 32'd7);
            chk($sformatf("stall%0d alu_ctrl", c),  32'(bus.alu_ctrl), 32'b0010);
            chk($sformatf("stall%0d write_reg", c), 32'(bus.ex_write_reg), 32'd4);
            chk($sformatf("stall%0d ex_valid", c),  32'(bus.ex_valid), 32'd1);
        end
        drive(vecs[7]);
        bus.flush = 1'b1;
        step();
        chk("flush ex_valid",     32'(bus.ex_valid), 32'd0);
        chk("flush ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
        chk("flush ex_mem_write", 32'(bus.ex_mem_write), 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Reset asserted mid-stream discards the captured instruction.
        drive(vecs[0]);
        step();
        chk("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("midreset ex_valid",  32'(bus.ex_valid), 32'd0);
        chk("midreset alu_ctrl",  32'(bus.alu_ctrl), 32'hF);
        chk("midreset alu_a",     bus.alu_a, 32'd0);
        chk("midreset write_reg", 32'(bus.ex_write_reg), 32'd0);
        chk("midreset reg_write", 32'(bus.ex_reg_write), 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
